// File: rtl/des_mux_pkg.sv
// des_mux_pkg: shared state encoding, default sizing and helpers for the design mux.
package des_mux_pkg;
  typedef enum logic [1:0] {RUN, QUIESCE, RESET} state_t;
  localparam int NUM_DES_D        = 64;
  localparam int IO_W_D           = 12;
  localparam int SYNC_STAGES_D    = 2;
  localparam int QUIESCE_CYCLES_D = 2;
  localparam int RST_CYCLES_D     = 8;
  function automatic int slice_lo(input int i, input int w);
    return i * w;
  endfunction
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/des_mux_sync.sv
// des_mux_sync: STAGES-deep, W-bit flop synchroniser with synchronous clear.
module des_mux_sync #(
  parameter int STAGES = 2,
  parameter int W      = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] ff [STAGES];
  always_ff @(posedge clock) begin
    if (reset) ff <= '{default: '0};
    else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end
  assign q = ff[STAGES-1];
endmodule

// File: rtl/des_mux_ctrl.sv
// des_mux_ctrl: pad-to-design mux with debounced select and quiesce-then-reset switching.
// Optional DES_MUX_TOGGLE_CNT_EN adds toggle_cnt (io_out changes seen in RUN).
module des_mux_ctrl
  import des_mux_pkg::*;
#(
  parameter int NUM_DES        = NUM_DES_D,
  parameter int IO_W           = IO_W_D,
  parameter int SEL_W          = $clog2(NUM_DES),
  parameter int SYNC_STAGES    = SYNC_STAGES_D,
  parameter int QUIESCE_CYCLES = QUIESCE_CYCLES_D,
  parameter int RST_CYCLES     = RST_CYCLES_D
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        des_sel,
  input  logic                    hold_if_not_sel,
  input  logic                    sync_inputs,
  input  logic [IO_W-1:0]         io_in,
  output logic [IO_W-1:0]         io_out,
  output logic [NUM_DES*IO_W-1:0] des_io_in,
  input  logic [NUM_DES*IO_W-1:0] des_io_out,
  output logic [NUM_DES-1:0]      des_en,
  output logic [NUM_DES-1:0]      des_reset,
  output logic [SEL_W-1:0]        sel_active,
`ifdef DES_MUX_TOGGLE_CNT_EN
  output logic [15:0]             toggle_cnt,
`endif
  output logic                    switching
);
  localparam int CNT_W = $clog2(max2(QUIESCE_CYCLES, RST_CYCLES)) + 1;
  localparam int IDX_W = $clog2(NUM_DES);
  logic [SEL_W-1:0] sel_s, sel_prev, cand, pend_sel, go_sel;
  logic hold_s, sync_s, pending, stable, valid, go, last_q, last_r;
  logic [IO_W-1:0] io_sync;
  logic [IO_W-1:0] out_arr [NUM_DES];
  logic [NUM_DES-1:0] oh;
  logic [CNT_W-1:0] cnt;
  state_t state, state_n;
  des_mux_sync #(.STAGES(SYNC_STAGES), .W(SEL_W + 2)) u_ctrl_sync (
    .clock(clock),
    .reset(reset),
    .d({des_sel, hold_if_not_sel, sync_inputs}),
    .q({sel_s, hold_s, sync_s})
  );
  des_mux_sync #(.STAGES(SYNC_STAGES), .W(IO_W)) u_io_sync (
    .clock(clock),
    .reset(reset),
    .d(io_in),
    .q(io_sync)
  );
  assign des_io_in = {NUM_DES{sync_s ? io_sync : io_in}};
  for (genvar g = 0; g < NUM_DES; g++) begin : g_out
    assign out_arr[g] = des_io_out[slice_lo(g, IO_W) +: IO_W];
  end
  // A fresh stable select wins over an older pending one latched mid-switch.
  always_comb begin
    stable  = sel_s == sel_prev;
    valid   = stable && ({1'b0, sel_s} < (SEL_W + 1)'(NUM_DES));
    go_sel  = valid ? sel_s : pend_sel;
    go      = state == RUN && (valid ? sel_s != sel_active : pending && pend_sel != sel_active);
    last_q  = cnt == CNT_W'(QUIESCE_CYCLES - 1);
    last_r  = cnt == CNT_W'(RST_CYCLES - 1);
    state_n = state == RUN ? (go ? QUIESCE : RUN)
            : state == QUIESCE ? (last_q ? RESET : QUIESCE)
            : (last_r ? RUN : RESET);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RUN;
      cnt        <= '0;
      sel_prev   <= '0;
      sel_active <= '0;
      cand       <= '0;
      pending    <= 1'b0;
      pend_sel   <= '0;
      io_out     <= '0;
    end else begin
      state    <= state_n;
      sel_prev <= sel_s;
      cnt      <= (state_n != state || state == RUN) ? '0 : cnt + 1'b1;
      if (go) begin
        cand    <= go_sel;
        pending <= 1'b0;
      end else if (state != RUN && valid) begin
        pending  <= sel_s != cand;
        pend_sel <= sel_s;
      end
      if (state == QUIESCE && state_n == RESET) sel_active <= cand;
      io_out <= state_n == RUN ? out_arr[IDX_W'(sel_active)] : '0;
    end
  end
  always_comb begin
    oh        = NUM_DES'(1) << sel_active;
    switching = state != RUN;
    des_reset = reset ? '1 : state == RESET ? oh : '0;
    des_en    = (reset || !hold_s) ? '1 : oh;
  end
`ifdef DES_MUX_TOGGLE_CNT_EN
  logic [IO_W-1:0] io_prev;
  always_ff @(posedge clock) begin
    io_prev <= reset ? '0 : io_out;
    if (reset || (state == RUN && state_n == QUIESCE)) toggle_cnt <= '0;
    else if (state == RUN && io_out != io_prev) toggle_cnt <= toggle_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_des_mux_ctrl.sv
// tb_des_mux_ctrl: directed checks of select debounce, switch sequencing, routing and enables.
module tb_des_mux_ctrl;
  localparam int ND = 64;
  localparam int IW = 12;
  localparam int SW = 7;
  logic clock = 1'b0;
  logic reset;
  logic [SW-1:0] des_sel;
  logic hold_if_not_sel, sync_inputs;
  logic [IW-1:0] io_in, io_out;
  logic [ND*IW-1:0] des_io_in, des_io_out;
  logic [ND-1:0] des_en, des_reset;
  logic [SW-1:0] sel_active;
  logic switching;
`ifdef DES_MUX_TOGGLE_CNT_EN
  logic [15:0] toggle_cnt;
`endif
  int checks = 0;
  int errors = 0;
  des_mux_ctrl #(.NUM_DES(ND), .IO_W(IW), .SEL_W(SW)) dut (
    .clock(clock),
    .reset(reset),
    .des_sel(des_sel),
    .hold_if_not_sel(hold_if_not_sel),
    .sync_inputs(sync_inputs),
    .io_in(io_in),
    .io_out(io_out),
    .des_io_in(des_io_in),
    .des_io_out(des_io_out),
    .des_en(des_en),
    .des_reset(des_reset),
    .sel_active(sel_active),
`ifdef DES_MUX_TOGGLE_CNT_EN
    .toggle_cnt(toggle_cnt),
`endif
    .switching(switching)
  );
  always #5 clock = ~clock;
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic set_out(input int i, input logic [IW-1:0] v);
    des_io_out[i*IW +: IW] = v;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    des_sel = '0;
    hold_if_not_sel = 1'b0;
    sync_inputs = 1'b0;
    io_in = '0;
    des_io_out = '0;
    for (int i = 0; i < ND; i++) set_out(i, 12'h100 + IW'(i));
    set_out(0, 12'hA5A);
    tick(3);
    chk("rst_des_reset", des_reset, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_des_en", des_en, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_io_out", io_out, 0);
    chk("rst_switching", switching, 0);
    chk("rst_sel_active", sel_active, 0);
    reset = 1'b0;
    tick(1);
    chk("rel_des_reset", des_reset, 0);
    chk("rel_io_out", io_out, 12'hA5A);
    chk("rel_switching", switching, 0);
    io_in = 12'h3C3;
    #1;
    chk("comb_in_lo", des_io_in[IW-1:0], 12'h3C3);
    chk("comb_in_hi", des_io_in[ND*IW-1 -: IW], 12'h3C3);
    sync_inputs = 1'b1;
    tick(3);
    chk("sync_in_a", des_io_in[IW-1:0], 12'h3C3);
    io_in = 12'h0F0;
    #1;
    chk("sync_in_hold", des_io_in[IW-1:0], 12'h3C3);
    tick(2);
    chk("sync_in_b", des_io_in[20*IW +: IW], 12'h0F0);
    sync_inputs = 1'b0;
    tick(3);
    io_in = 12'h111;
    #1;
    chk("comb_in_back", des_io_in[10*IW +: IW], 12'h111);
    des_sel = 7'd5;
    tick(3);
    chk("sw5_early", switching, 0);
    tick(1);
    chk("sw5_switching", switching, 1);
    chk("sw5_q_io_out", io_out, 0);
    chk("sw5_q_sel", sel_active, 0);
    tick(1);
    chk("sw5_q_des_reset", des_reset, 0);
    tick(1);
    chk("sw5_r_des_reset", des_reset, 64'h1 << 5);
    chk("sw5_r_sel", sel_active, 5);
    tick(7);
    chk("sw5_r_last", des_reset, 64'h1 << 5);
    chk("sw5_r_io_out", io_out, 0);
    tick(1);
    chk("sw5_run_des_reset", des_reset, 0);
    chk("sw5_run_switching", switching, 0);
    chk("sw5_run_io_out", io_out, 12'h105);
    set_out(5, 12'hABC);
    tick(1);
    chk("sw5_track", io_out, 12'hABC);
    des_sel = 7'd9;
    tick(1);
    des_sel = 7'd5;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("glitch_switching", switching, 0);
    end
    chk("glitch_sel", sel_active, 5);
    des_sel = 7'd3;
    tick(4);
    chk("sw3_switching", switching, 1);
    tick(10);
    chk("sw3_done", switching, 0);
    chk("sw3_sel", sel_active, 3);
    hold_if_not_sel = 1'b1;
    tick(3);
    chk("hold_en", des_en, 64'h8);
    hold_if_not_sel = 1'b0;
    tick(3);
    chk("nohold_en", des_en, 64'hFFFF_FFFF_FFFF_FFFF);
    des_sel = 7'd5;
    tick(4);
    chk("pend_sw5", switching, 1);
    tick(2);
    chk("pend_sel5", sel_active, 5);
    tick(2);
    des_sel = 7'd7;
    tick(6);
    chk("pend_run_sw", switching, 0);
    chk("pend_run_sel", sel_active, 5);
    chk("pend_run_io", io_out, 12'hABC);
    tick(1);
    chk("pend_sw7", switching, 1);
    chk("pend_sw7_io", io_out, 0);
    tick(2);
    chk("pend_sel7", sel_active, 7);
    chk("pend_rst7", des_reset, 64'h1 << 7);
    tick(8);
    chk("pend_done", switching, 0);
    chk("pend_io7", io_out, 12'h107);
    des_sel = 7'd70;
    tick(6);
    chk("oor_switching", switching, 0);
    tick(4);
    chk("oor_sel", sel_active, 7);
    des_sel = 7'd2;
    tick(4);
    chk("rq_switching", switching, 1);
    reset = 1'b1;
    des_sel = '0;
    tick(1);
    chk("rq_switching0", switching, 0);
    chk("rq_sel", sel_active, 0);
    chk("rq_io_out", io_out, 0);
    chk("rq_des_reset", des_reset, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef DES_MUX_TOGGLE_CNT_EN
    chk("rq_toggle", toggle_cnt, 0);
`endif
    reset = 1'b0;
    tick(1);
    chk("rq_rel_io", io_out, 12'hA5A);
    chk("rq_rel_sw", switching, 0);
`ifdef DES_MUX_TOGGLE_CNT_EN
    tick(1);
    chk("toggle_1", toggle_cnt, 1);
    set_out(0, 12'h5A5);
    tick(2);
    chk("toggle_2", toggle_cnt, 2);
    chk("toggle_io", io_out, 12'h5A5);
`else
    set_out(0, 12'h5A5);
    tick(1);
    chk("rq_track", io_out, 12'h5A5);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/des_mux_ctrl.md
Name: des_mux_ctrl

Overview:
- Parametrised design multiplexer and controller. It sits between the padframe IOs and N student designs.
- Synchronises and debounces the design-select bus and routes pad inputs to every design.
- Registers the selected design's outputs back to the pads.
- On each select change it runs a quiesce-then-reset sequence, so a newly selected design always starts from a clean reset and never glitches the pads.

Parameters:
- NUM_DES, 64, number of design slots.
- IO_W, 12, pad input/output width per design.
- SEL_W, $clog2(NUM_DES), select bus width.
- SYNC_STAGES, 2, flop stages on async pad inputs (minimum 2).
- QUIESCE_CYCLES, 2, cycles io_out is forced to 0 before the new design's reset.
- RST_CYCLES, 8, cycles the new design's reset is held.

Ports:
- clock  in  1  design clock; all logic on posedge.
- reset  in  1  synchronous, active-high; already synchronised upstream.
- des_sel  in  SEL_W  async pad select bus.
- hold_if_not_sel  in  1  async; 1 = freeze non-selected designs.
- sync_inputs  in  1  async; 1 = route io_in through the synchroniser.
- io_in  in  IO_W  pad inputs.
- io_out  out  IO_W  pad outputs, registered.
- des_io_in  out  NUM_DES*IO_W  fan-out to designs; slice i = design i.
- des_io_out  in  NUM_DES*IO_W  design outputs; slice i = design i.
- des_en  out  NUM_DES  per-design clock enable.
- des_reset  out  NUM_DES  per-design synchronous, active-high reset.
- sel_active  out  SEL_W  currently committed selection.
- switching  out  1  high while the FSM is not in RUN.

Behaviour:
- Control input synchronisation: des_sel, hold_if_not_sel and sync_inputs each pass through SYNC_STAGES flops.
- Select debounce:
  - A candidate select is accepted only when the synchronised value is equal on 2 consecutive cycles and differs from sel_active.
  - Values >= NUM_DES are ignored: no switch, sel_active is unchanged.
- Input routing:
  - sync_inputs_s=1: des_io_in slices = io_in after SYNC_STAGES flops.
  - sync_inputs_s=0: des_io_in slices = io_in combinationally.
  - The same value is broadcast to all slices.
- FSM states: RUN, QUIESCE, RESET.
  - RUN -> QUIESCE on an accepted new select.
  - QUIESCE: counter counts QUIESCE_CYCLES cycles, io_out forced to 0, then commit sel_active <= candidate and go to RESET.
  - RESET: des_reset[sel_active]=1 for exactly RST_CYCLES cycles, io_out stays 0, then go to RUN.
  - A select change during QUIESCE or RESET is latched as pending. It is taken on the first RUN cycle, giving one RUN cycle minimum; a switch is never aborted mid-sequence.
- Output path: in RUN, io_out <= des_io_out[sel_active] on the next edge (1-cycle latency).
- Enables:
  - hold_s=0: des_en all 1.
  - hold_s=1: des_en = one-hot(sel_active).
  - During RESET, des_en[sel_active]=1 always.
- Top-level reset (reset=1):
  - Every des_reset bit = 1 and des_en all 1.
  - sel_active=0, io_out=0, switching=0, FSM state = RUN, synchroniser flops cleared, pending cleared.
  - Synchronous reset wins over any in-flight switch. After release the FSM is in RUN with design 0; no extra reset sequence runs.
- Counters are $clog2(max(QUIESCE_CYCLES,RST_CYCLES))+1 bits and saturate safely; RST_CYCLES=1 is legal.

Optional Feature:
- Macro: DES_MUX_TOGGLE_CNT_EN.
- With the macro defined:
  - Adds output toggle_cnt[15:0], which counts cycles in RUN where io_out changed value.
  - The counter wraps at 16 bits.
  - It clears on reset and on entry to QUIESCE.
- Without the macro: the port and the counter are absent, and other behaviour is identical.

Decomposition:
- Shared package des_mux_pkg holds:
  - state enum (RUN, QUIESCE, RESET);
  - default parameter constants;
  - slice-index helper function.
- One sub-module: des_mux_sync (a parametrised N-stage, W-bit synchroniser with synchronous clear), instantiated for the control bits and for io_in.

Test Plan:
- Reset release with des_sel=0 and des_io_out[0]=12'hA5A: io_out=12'hA5A exactly 1 cycle after the first RUN edge; all des_reset drop together.
- Change des_sel 0->5 held stable:
  - switching rises SYNC_STAGES+2 cycles later;
  - io_out=0 for 2+8 cycles;
  - des_reset[5] high exactly 8 cycles;
  - sel_active=5;
  - then io_out tracks des_io_out[5].
- 1-cycle glitch on des_sel 5->9->5: no switch; switching stays 0.
- hold_if_not_sel=1, sel=3: des_en=64'h8 after sync; set hold=0: des_en all ones.
- Select 7 issued mid-RESET of a switch to 5: the 5 sequence completes, one RUN cycle follows, then a full sequence to 7 runs; des_sel=70 with NUM_DES=64 is ignored.
- Reset asserted in QUIESCE: next cycle state=RUN, sel_active=0, io_out=0; with DES_MUX_TOGGLE_CNT_EN, toggle_cnt=0 and it increments once per io_out change in RUN.
